// File: rtl/text_rx_pkg.sv
// Shared ASCII control codes, FSM state encoding and character classification
// for the text receiver.
package text_rx_pkg;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WRITE,
    CLEAR,
    ECHO
  } state_t;

  function automatic logic is_printable(input logic [6:0] code);
    return (code >= 7'h20) && (code <= 7'h7E);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with first-word-fall-through read; DEPTH must be a power of 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_receiver.sv
// UART byte receiver driving a character-cell display with cursor, backspace, CR and clear.
// Define TEXT_RX_ECHO_EN to echo each written printable byte back toward the UART transmitter.
module text_receiver
  import text_rx_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int CELLS = COLS * ROWS,
  localparam int AW    = $clog2(CELLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          disp_ready,
  output logic          disp_we,
  output logic [AW-1:0] disp_addr,
  output logic [7:0]    disp_char,
  output logic [AW-1:0] cursor,
  output logic          busy,
  output logic          overflow,
`ifdef TEXT_RX_ECHO_EN
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
`endif
  output logic [11:0]   led
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_next;
  logic [7:0]    cur_byte;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_char;
  logic          wr_adv;
  logic [AW-1:0] clr_addr;
  logic [8:0]    led_byte;
  logic [2:0]    occupancy;

  logic          pop, full, empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] count;

  logic          is_print, is_bs, is_cr, is_esc;
  logic          clr_last;
  logic [AW-1:0] cursor_inc, cr_target;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Classification ignores the lang bit.
  assign is_print   = is_printable(cur_byte[6:0]);
  assign is_bs      = (cur_byte[6:0] == ASCII_BS[6:0]);
  assign is_cr      = (cur_byte[6:0] == ASCII_CR[6:0]);
  assign is_esc     = (cur_byte[6:0] == ASCII_ESC[6:0]);
  assign clr_last   = (clr_addr == AW'(CELLS - 1));
  assign cursor_inc = (cursor == AW'(CELLS - 1)) ? '0 : cursor + 1'b1;
  assign cr_target  = (int'(cursor) / COLS == ROWS - 1) ? '0
                    : AW'((int'(cursor) / COLS + 1) * COLS);

  assign occupancy = (int'(count) > 7) ? 3'd7 : 3'(count);
  assign led       = {occupancy, led_byte};
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    disp_we    = 1'b0;
    disp_addr  = '0;
    disp_char  = '0;
`ifdef TEXT_RX_ECHO_EN
    tx_start   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (is_print)                   state_next = WRITE;
        else if (is_bs && cursor != '0) state_next = WRITE;
        else if (is_esc)                state_next = CLEAR;
        else                            state_next = IDLE;
      end
      WRITE: begin
        disp_we   = 1'b1;
        disp_addr = wr_addr;
        disp_char = wr_char;
        if (disp_ready) begin
`ifdef TEXT_RX_ECHO_EN
          state_next = wr_adv ? ECHO : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
      CLEAR: begin
        disp_we   = 1'b1;
        disp_addr = clr_addr;
        disp_char = ASCII_SPACE;
        if (disp_ready && clr_last) state_next = IDLE;
      end
      ECHO: begin
`ifdef TEXT_RX_ECHO_EN
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_byte <= '0;
      wr_addr  <= '0;
      wr_char  <= '0;
      wr_adv   <= 1'b0;
      clr_addr <= '0;
      cursor   <= '0;
      led_byte <= '0;
      overflow <= 1'b0;
`ifdef TEXT_RX_ECHO_EN
      tx_data  <= '0;
`endif
    end else begin
      if (rx_valid && full && !pop) overflow <= 1'b1;
      unique case (state)
        IDLE: if (pop) cur_byte <= fifo_dout;
        DECODE: begin
          led_byte <= {cur_byte[7], cur_byte};
          if (is_print) begin
            wr_addr <= cursor;
            wr_char <= cur_byte;
            wr_adv  <= 1'b1;
          end else if (is_bs && cursor != '0) begin
            cursor  <= cursor - 1'b1;
            wr_addr <= cursor - 1'b1;
            wr_char <= ASCII_SPACE;
            wr_adv  <= 1'b0;
          end else if (is_cr) begin
            cursor <= cr_target;
          end else if (is_esc) begin
            clr_addr <= '0;
          end
        end
        WRITE: begin
          if (disp_ready && wr_adv) begin
            cursor <= cursor_inc;
`ifdef TEXT_RX_ECHO_EN
            tx_data <= cur_byte;
`endif
          end
        end
        CLEAR: begin
          if (disp_ready) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_last) cursor <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/text_receiver.md
Name: text_receiver

Overview:
Receive-side counterpart of the keyboard/switch UART sender. Accepts received UART bytes as {lang, ascii[6:0]}, buffers them in a small FIFO, and decodes printable characters and control codes. Drives a character-cell display write port with a managed cursor, and feeds LEDs with status. Sits between the uart receive outputs (data plus one-cycle write strobe) and the display text RAM.

Parameters:
COLS, 32, characters per row
ROWS, 8, rows on screen; CELLS = COLS*ROWS, AW = clog2(CELLS)
FIFO_DEPTH, 8, input byte FIFO depth (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte; bit7 = lang flag, bits[6:0] = ascii
rx_valid  in  1  one-cycle strobe, rx_data valid
disp_ready  in  1  display accepts a write this cycle
disp_we  out  1  display write request
disp_addr  out  AW  cell address = row*COLS + col
disp_char  out  8  {lang, ascii7} written to cell
cursor  out  AW  next write cell
busy  out  1  FSM not in IDLE or FIFO non-empty
overflow  out  1  sticky: a byte was dropped
led  out  12  [7:0] last decoded byte, [8] its lang bit, [11:9] FIFO occupancy (saturates at 7)

Behaviour:
- Reset (async, active-high): all outputs 0; FIFO emptied; FSM to IDLE; cursor 0. Takes effect mid-write; disp_we drops immediately.
- FIFO push: on rx_valid when not full, or when full and a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set (cleared only by reset).
- FSM IDLE: if FIFO non-empty, pop into cur_byte and go to DECODE.
- FSM DECODE: classify on cur_byte[6:0]; the lang bit is ignored for classification. Update led[8:0] = cur_byte.
  - 0x20-0x7E: go to WRITE with addr=cursor, char=cur_byte.
  - 0x08 (BS): if cursor==0, no-op and go to IDLE. Else cursor <= cursor-1, then WRITE a space (8'h20) at the new cursor; cursor does not advance afterwards.
  - 0x0D (CR): cursor <= start of next row; last row wraps to 0; go to IDLE (no write).
  - 0x1B (ESC): go to CLEAR with clr_addr=0.
  - All other codes, including 0x00: ignored, go to IDLE.
- FSM WRITE: disp_we=1 with addr/char held stable until disp_ready is sampled 1. On that cycle the write completes. For printable characters the cursor then advances by 1, wrapping CELLS-1 -> 0. Return to IDLE.
- FSM CLEAR: disp_we=1, char=8'h20, addr=clr_addr. clr_addr increments on each accepted write. After address CELLS-1 is accepted: cursor=0, go to IDLE.
- Minimum latency: rx_valid at cycle N -> disp_we first high at N+3 (push N, pop N+1, decode N+2, write N+3). Throughput is one printable byte per 3 cycles with disp_ready held high.
- FIFO continues accepting bytes during WRITE and CLEAR.

Optional Feature:
Macro TEXT_RX_ECHO_EN.
- Defined: adds ports tx_data (out 8), tx_start (out 1), tx_busy (in 1) toward the uart transmitter.
  - After each completed printable WRITE, the FSM enters ECHO.
  - ECHO waits while tx_busy=1, then pulses tx_start for one cycle with tx_data=cur_byte, then returns to IDLE.
  - tx_data and tx_start reset to 0.
- Undefined: ports absent; WRITE returns directly to IDLE.

Decomposition:
- Shared package text_rx_pkg holds:
  - constants ASCII_BS=8'h08, ASCII_CR=8'h0D, ASCII_ESC=8'h1B, ASCII_SPACE=8'h20;
  - the FSM state typedef (IDLE, DECODE, WRITE, CLEAR, ECHO).
- One sub-module, byte_fifo: parameterised depth, async reset, push/pop/full/empty/count.

Test Plan:
- Reset, then bytes 0x48, 0xC1 with disp_ready=1 -> writes (addr0,0x48), (addr1,0xC1); cursor=2; led[8:0]=0x1C1.
- Cursor at 5, send 0x08 -> write (addr4,0x20); cursor=4. With cursor=0, send 0x08 -> no disp_we; cursor stays 0.
- Cursor at 35 (COLS=32), send 0x0D -> cursor=64, no write. At cursor 230, send 0x0D -> cursor=0. Cursor 255 plus a printable byte -> write addr255, then cursor=0.
- Send 0x1B with disp_ready toggling 1/0 -> exactly 256 accepted writes of 0x20 to addr 0..255 in order; cursor=0; busy drops.
- Hold disp_ready=0 and push 10 bytes -> first is popped, FIFO holds 8, 10th dropped, overflow=1, led[11:9]=7. Release disp_ready -> 9 writes total.
- Assert reset during CLEAR at clr_addr=100 -> disp_we=0 in the same cycle, cursor=0, FIFO empty, overflow=0. With TEXT_RX_ECHO_EN: send 0x41 while tx_busy=1 for 5 cycles -> tx_start pulses once after tx_busy falls, tx_data=0x41.
